// File: rtl/inst_pkg.sv
// rtl/inst_pkg.sv - shared types and field positions for the instruction encode loader
package inst_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int OPC_LSB = 26;
  localparam int RD_LSB  = 21;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 11;
  localparam int SH_LSB  = 6;

  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int JUMP_W  = 26;

endpackage

// File: rtl/inst_encode_loader_if.sv
// rtl/inst_encode_loader_if.sv - field bundle stream and memory write port
interface inst_encode_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [1:0]        fmt;
  logic [5:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        shift;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       jump;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_last, fmt, opcode, rd, rs, rt, shift, funct, imm, jump,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_last, fmt, opcode, rd, rs, rt, shift, funct, imm, jump,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_field_pack.sv
// rtl/inst_field_pack.sv - combinational packing of R/I/J field bundles into a 32-bit word
module inst_field_pack
  import inst_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  shift,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] jump,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[OPC_LSB +: OPC_W] = opcode;
    case (fmt_e'(fmt))
      FMT_R: begin
        word[RD_LSB +: REG_W]  = rd;
        word[RS_LSB +: REG_W]  = rs;
        word[RT_LSB +: REG_W]  = rt;
        word[SH_LSB +: REG_W]  = shift;
        word[0 +: FUNCT_W]     = funct;
      end
      FMT_I: begin
        word[RD_LSB +: REG_W]  = rd;
        word[RS_LSB +: REG_W]  = rs;
        word[0 +: IMM_W]       = imm;
      end
      FMT_J: begin
        word[0 +: JUMP_W]      = jump;
      end
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encode_loader.sv
// rtl/inst_encode_loader.sv - session FSM, one-stage encode pipeline and address/count tracking
// Optional XOR checksum of written words when INST_LOADER_CHECKSUM_EN is defined.
module inst_encode_loader
  import inst_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  inst_encode_loader_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                err_fmt,
  output logic                err_full,
  output logic [ADDR_W:0]     word_count
`ifdef INST_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]         checksum
`endif
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(MAX_WORDS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     acc_q, acc_d;
  logic                wr_valid_q, wr_valid_d;
  logic [31:0]         wr_word_q, wr_word_d;
  logic                err_fmt_q, err_fmt_d;
  logic                err_full_q, err_full_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
`endif

  logic [31:0]         packed_word;
  logic                packed_bad;
  logic                accept;

  inst_field_pack u_pack (
    .fmt     (bus.fmt),
    .opcode  (bus.opcode),
    .rd      (bus.rd),
    .rs      (bus.rs),
    .rt      (bus.rt),
    .shift   (bus.shift),
    .funct   (bus.funct),
    .imm     (bus.imm),
    .jump    (bus.jump),
    .word    (packed_word),
    .illegal (packed_bad)
  );

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.mem_we    = wr_valid_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wr_word_q;
  assign busy          = (state_q != ST_IDLE);
  assign err_fmt       = err_fmt_q;
  assign err_full      = err_full_q;
  assign word_count    = count_q;
`ifdef INST_LOADER_CHECKSUM_EN
  assign checksum      = csum_q;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    acc_d      = acc_q;
    wr_valid_d = 1'b0;
    wr_word_d  = wr_word_q;
    err_fmt_d  = err_fmt_q;
    err_full_d = err_full_q;
    done       = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    // Address and count advance as each write leaves the pipeline register.
    if (wr_valid_q) begin
      addr_d  = addr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W+1)'(1);
`ifdef INST_LOADER_CHECKSUM_EN
      csum_d  = csum_q ^ wr_word_q;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          addr_d     = base_addr;
          count_d    = '0;
          acc_d      = '0;
          err_fmt_d  = 1'b0;
          err_full_d = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (packed_bad) begin
            err_fmt_d = 1'b1;
            if (bus.in_last) state_d = ST_FLUSH;
          end else begin
            wr_valid_d = 1'b1;
            wr_word_d  = packed_word;
            acc_d      = acc_q + (ADDR_W+1)'(1);
            if (bus.in_last) begin
              state_d = ST_FLUSH;
            end else if (acc_q == LAST_CNT) begin
              state_d    = ST_FLUSH;
              err_full_d = 1'b1;
            end
          end
        end
      end
      ST_FLUSH: begin
        // Hold until the final write has drained so done sees the final count.
        if (!wr_valid_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_word_q  <= '0;
      err_fmt_q  <= 1'b0;
      err_full_q <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      wr_valid_q <= wr_valid_d;
      wr_word_q  <= wr_word_d;
      err_fmt_q  <= err_fmt_d;
      err_full_q <= err_full_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_encode_loader.sv
// tb/tb_inst_encode_loader.sv - directed self-checking bench for inst_encode_loader (MAX_WORDS=4)
module tb_inst_encode_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic       busy;
  logic       done;
  logic       err_fmt;
  logic       err_full;
  logic [8:0] word_count;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  inst_encode_loader_if #(.ADDR_W(8)) bus ();

  inst_encode_loader #(.ADDR_W(8), .MAX_WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .err_fmt    (err_fmt),
    .err_full   (err_full),
    .word_count (word_count)
`ifdef INST_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int cyc       = 0;
  int acc_cnt   = 0;

  logic [7:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wq_addr.push_back(bus.mem_addr);
      wq_data.push_back(bus.mem_wdata);
      wq_cyc.push_back(cyc);
    end
    if (bus.in_valid && bus.in_ready) acc_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] data_at(input int i);
    return (i < wq_data.size()) ? wq_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [7:0] addr_at(input int i);
    return (i < wq_addr.size()) ? wq_addr[i] : 8'hEE;
  endfunction

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    acc_cnt = 0;
  endtask

  task automatic do_start(input logic [7:0] b);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic offer(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] c, input logic [4:0] d,
                       input logic [5:0] fn, input logic [15:0] im, input logic [25:0] jp,
                       input logic last, output logic acc);
    logic rdy;
    bus.in_valid = 1'b1;
    bus.fmt      = f;
    bus.opcode   = op;
    bus.rd       = a;
    bus.rs       = b;
    bus.rt       = c;
    bus.shift    = d;
    bus.funct    = fn;
    bus.imm      = im;
    bus.jump     = jp;
    bus.in_last  = last;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq(tag, seen, 1'b1);
  endtask

  logic acc;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.fmt = '0; bus.opcode = '0;
    bus.rd = '0; bus.rs = '0; bus.rt = '0; bus.shift = '0; bus.funct = '0;
    bus.imm = '0; bus.jump = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_we", bus.mem_we, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_word_count", word_count, 0);
    check_eq("rst_err", {err_fmt, err_full}, 0);
    rst = 1'b0;

    // Single R word with last
    clear_log();
    do_start(8'h10);
    check_eq("t1_busy", busy, 1);
    offer(2'd0, 6'd0, 5'd3, 5'd1, 5'd2, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, acc);
    idle_in();
    check_eq("t1_acc", acc, 1);
    wait_done("t1_done");
    check_eq("t1_word_count", word_count, 1);
    check_eq("t1_err", {err_fmt, err_full}, 0);
    check_eq("t1_nwrites", wq_data.size(), 1);
    check_eq("t1_addr", addr_at(0), 8'h10);
    check_eq("t1_data", data_at(0), 32'h0061_1020);
    @(negedge clk);
    check_eq("t1_idle", busy, 0);

    // Back-to-back I then J
    clear_log();
    do_start(8'h30);
    offer(2'd1, 6'h08, 5'd5, 5'd4, 5'd0, 5'd0, 6'h0, 16'hFFFC, 26'h0, 1'b0, acc);
    offer(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1, acc);
    idle_in();
    wait_done("t2_done");
    check_eq("t2_nwrites", wq_data.size(), 2);
    check_eq("t2_addr0", addr_at(0), 8'h30);
    check_eq("t2_data0", data_at(0), 32'h20A4_FFFC);
    check_eq("t2_addr1", addr_at(1), 8'h31);
    check_eq("t2_data1", data_at(1), 32'h0800_0010);
    check_eq("t2_consecutive", (wq_cyc.size() == 2) ? wq_cyc[1] - wq_cyc[0] : -1, 1);
    check_eq("t2_word_count", word_count, 2);
`ifdef INST_LOADER_CHECKSUM_EN
    check_eq("t2_checksum", checksum, 32'h28A4_FFEC);
`endif

    // Illegal fmt mid-stream
    clear_log();
    do_start(8'h20);
    offer(2'd0, 6'd0, 5'd3, 5'd1, 5'd2, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0, acc);
    offer(2'd3, 6'h3F, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 1'b0, acc);
    check_eq("t3_bad_acc", acc, 1);
    offer(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1, acc);
    idle_in();
    wait_done("t3_done");
    check_eq("t3_err_fmt", err_fmt, 1);
    check_eq("t3_err_full", err_full, 0);
    check_eq("t3_nwrites", wq_data.size(), 2);
    check_eq("t3_addr1", addr_at(1), 8'h21);
    check_eq("t3_data1", data_at(1), 32'h0800_0010);
    check_eq("t3_word_count", word_count, 2);

    // Full: five offered, no last, MAX_WORDS=4
    clear_log();
    do_start(8'h40);
    for (int i = 0; i < 4; i++) begin
      offer(2'd1, 6'h08, 5'd5, 5'd4, 5'd0, 5'd0, 6'h0, 16'(i), 26'h0, 1'b0, acc);
    end
    bus.imm = 16'd4;
    wait_done("t4_done");
    check_eq("t4_err_full", err_full, 1);
    check_eq("t4_err_fmt", err_fmt, 0);
    check_eq("t4_word_count", word_count, 4);
    repeat (3) @(negedge clk);
    check_eq("t4_in_ready_low", bus.in_ready, 0);
    idle_in();
    check_eq("t4_accepted", acc_cnt, 4);
    check_eq("t4_nwrites", wq_data.size(), 4);
    check_eq("t4_addr3", addr_at(3), 8'h43);
    check_eq("t4_data3", data_at(3), 32'h20A4_0003);

    // Address wrap
    clear_log();
    do_start(8'hFF);
    offer(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h1, 1'b0, acc);
    offer(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h2, 1'b1, acc);
    idle_in();
    wait_done("t5_done");
    check_eq("t5_addr0", addr_at(0), 8'hFF);
    check_eq("t5_addr1", addr_at(1), 8'h00);
    check_eq("t5_data1", data_at(1), 32'h0800_0002);
    check_eq("t5_word_count", word_count, 2);

    // Reset mid-stream drops the pending write
    clear_log();
    do_start(8'h80);
    offer(2'd0, 6'd0, 5'd3, 5'd1, 5'd2, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0, acc);
    rst = 1'b1;
    #1;
    check_eq("t6_mem_we", bus.mem_we, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_in_ready", bus.in_ready, 0);
    check_eq("t6_word_count", word_count, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_in();
    check_eq("t6_nwrites", wq_data.size(), 0);
    clear_log();
    do_start(8'h90);
    offer(2'd0, 6'd0, 5'd3, 5'd1, 5'd2, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, acc);
    idle_in();
    wait_done("t6_done");
    check_eq("t6_addr", addr_at(0), 8'h90);
    check_eq("t6_data", data_at(0), 32'h0061_1020);
    check_eq("t6_count", word_count, 1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/inst_encode_loader.md
Name: inst_encode_loader

Overview:
- Inverse of the instruction field decoder: packs per-format field bundles (R/I/J) into 32-bit instruction words and streams them into instruction memory through a write port.
- Used by the testbench/boot path to load programs without hand-built hex.
- Valid/ready input, one-cycle encode pipeline, sequential address counter, FSM controlling load sessions.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- MAX_WORDS, 256, words accepted per session (≤ 2**ADDR_W).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse; begins session at base_addr
- base_addr  input  ADDR_W  first write address, sampled on start
- in_valid  input  1  field bundle valid
- in_ready  output  1  bundle accepted when in_valid&in_ready
- in_last  input  1  bundle is final of session
- fmt  input  2  0=R, 1=I, 2=J, 3=illegal
- opcode  input  6  word[31:26]
- rd  input  5  word[25:21] (R, I)
- rs  input  5  word[20:16] (R, I)
- rt  input  5  word[15:11] (R)
- shift  input  5  word[10:6] (R)
- funct  input  6  word[5:0] (R)
- imm  input  16  word[15:0] (I)
- jump  input  26  word[25:0] (J)
- mem_we  output  1  write strobe
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  32  encoded word
- busy  output  1  session active
- done  output  1  one-cycle pulse at end of session
- err_fmt  output  1  sticky: illegal fmt seen this session
- err_full  output  1  sticky: session ended by MAX_WORDS
- word_count  output  ADDR_W+1  words written this session

Behaviour:
- Reset: all outputs 0, state IDLE, address/count 0, pipeline empty; in-flight write dropped.
- States: IDLE -> LOAD on start (latch base_addr, clear count/err flags). LOAD -> FLUSH on acceptance with in_last, or on acceptance bringing count to MAX_WORDS. FLUSH -> IDLE after pending write issues; done pulses that cycle.
- start ignored outside IDLE.
- in_ready = (state==LOAD) and not full; deasserted in IDLE/FLUSH.
- Latency: bundle accepted cycle N -> mem_we=1 cycle N+1 with mem_addr=current address, mem_wdata=encoded word. Throughput one word/cycle; address and word_count increment per write.
- Address wraps mod 2**ADDR_W (base near top wraps to 0).
- Encoding: R = {opcode,rd,rs,rt,shift,funct}; I = {opcode,rd,rs,imm}; J = {opcode,jump}. Unused inputs ignored.
- fmt=3: bundle accepted and consumed, no write, no address increment, err_fmt set; in_last on it still ends session.
- Full: the MAX_WORDS-th accepted bundle without in_last ends session, err_full=1 with done.
- done and err flags simultaneous; err flags held until next start.

Optional Feature:
- INST_LOADER_CHECKSUM_EN: adds output checksum [31:0] = XOR of all written words, cleared on start, valid when done pulses. Without macro: port and logic absent.

Decomposition:
- Package inst_pkg: fmt enum (FMT_R, FMT_I, FMT_J, FMT_BAD), field LSB/width constants (OPC_LSB=26, RD_LSB=21, RS_LSB=16, RT_LSB=11, SH_LSB=6), FSM state enum.
- Sub-module inst_field_pack: combinational fmt+fields -> 32-bit word plus illegal flag; top holds FSM, pipeline register, counters.

Test Plan:
- start base_addr=0x10; R opcode=0, rd=3, rs=1, rt=2, shift=0, funct=0x20, in_last=1 -> next cycle mem_we, addr 0x10, wdata 0x00611020; done, word_count=1.
- Back-to-back I (opcode 0x08, rd=5, rs=4, imm=0xFFFC) then J (opcode 0x02, jump 0x10, last) -> 0x20A4FFFC@base, 0x08000010@base+1 on consecutive cycles.
- fmt=3 bundle mid-stream -> no write, address unchanged, err_fmt=1 at done.
- MAX_WORDS=4, five bundles offered, no last -> 4 writes, in_ready low afterward, done with err_full=1.
- base_addr=0xFF, two words -> addresses 0xFF then 0x00.
- rst asserted while in_valid streaming -> outputs 0 immediately, no further mem_we; new start works normally.
